// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, even parity, 1 stop.
// Bit period is WORK_FR+1 PCLK cycles; rx line sampled at mid-bit.
module uart_rx #(
  parameter int WIDTH = 12
) (
  input  logic             PCLK,
  input  logic             RESET,
  input  logic             RX_I,
  input  logic [WIDTH-1:0] WORK_FR,
  output logic [7:0]       DATA_RX_O,
  output logic             READY_RX,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t           state_r, state_nx;
  logic [WIDTH-1:0] cnt_r, cnt_nx, cnt_inc_s, half_s;
  logic [2:0]       idx_r, idx_nx;
  logic [7:0]       shift_r, shift_nx;
  logic             par_r, par_nx;
  logic [7:0]       data_r, data_nx;
  logic             ready_r, ready_nx;
  logic             perr_r, perr_nx;
  logic             ferr_r, ferr_nx;
  logic             busy_r;
  logic             rx_meta_r, rx_sync_r, rx_s;
  logic             at_half_s, at_end_s;

  assign rx_s      = rx_sync_r;
  assign half_s    = WORK_FR >> 1;
  assign at_half_s = (cnt_r == half_s);
  assign at_end_s  = (cnt_r == WORK_FR);
  assign cnt_inc_s = at_end_s ? {WIDTH{1'b0}} : (cnt_r + WIDTH'(1));

  // Next-state and datapath decisions; all sampling uses the synchronized line
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    par_nx   = par_r;
    data_nx  = data_r;
    ready_nx = 1'b0;
    perr_nx  = perr_r;
    ferr_nx  = ferr_r;
    case (state_r)
      IDLE: begin
        cnt_nx = {WIDTH{1'b0}};
        if (!rx_s) begin
          state_nx = START;
          idx_nx   = 3'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        cnt_nx = cnt_inc_s;
        if (at_half_s && rx_s) begin
          state_nx = IDLE;
          cnt_nx   = {WIDTH{1'b0}};
        end else if (at_end_s) begin
          state_nx = DATA;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        cnt_nx = cnt_inc_s;
        if (at_half_s) begin
          shift_nx = {rx_s, shift_r[7:1]};
        end else begin
          shift_nx = shift_r;
        end
        if (at_end_s) begin
          if (idx_r == 3'd7) begin
            state_nx = PARITY;
          end else begin
            idx_nx = idx_r + 3'd1;
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        cnt_nx = cnt_inc_s;
        if (at_half_s) begin
          par_nx = rx_s;
        end else begin
          par_nx = par_r;
        end
        if (at_end_s) begin
          state_nx = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        cnt_nx = cnt_inc_s;
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (at_half_s) begin
          data_nx  = shift_r;
          perr_nx  = par_r ^ even_parity(shift_r);
          ferr_nx  = ~rx_s;
          ready_nx = 1'b1;
          state_nx = IDLE;
          cnt_nx   = {WIDTH{1'b0}};
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = {WIDTH{1'b0}};
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs
  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= IDLE;
      cnt_r     <= {WIDTH{1'b0}};
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      data_r    <= 8'h00;
      ready_r   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      rx_meta_r <= RX_I;
      rx_sync_r <= rx_meta_r;
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      idx_r     <= idx_nx;
      shift_r   <= shift_nx;
      par_r     <= par_nx;
      data_r    <= data_nx;
      ready_r   <= ready_nx;
      perr_r    <= perr_nx;
      ferr_r    <= ferr_nx;
      busy_r    <= (state_nx != IDLE);
    end
  end

  assign DATA_RX_O  = data_r;
  assign READY_RX   = ready_r;
  assign PARITY_ERR = perr_r;
  assign FRAME_ERR  = ferr_r;
  assign BUSY       = busy_r;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver. Consumes the frame produced by the team's UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit (1).
- Bit period is WORK_FR+1 PCLK cycles, the same programmed divisor the transmitter uses.
- Sits directly downstream of the transmitter's TX_O (loopback) or of the external RX pin. Delivers one byte per frame with a one-cycle valid strobe and error flags.

Parameters:
- WIDTH, 12, width of the internal bit-period counter; WORK_FR must fit in WIDTH bits.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- RX_I  input  1  serial line, asynchronous to PCLK; idle high.
- WORK_FR  input  12  bit period minus one, in PCLK cycles; must be >= 3 and stable while BUSY=1.
- DATA_RX_O  output  8  last received byte; holds until the next accepted frame.
- READY_RX  output  1  one-cycle pulse when a frame completes (good or errored).
- PARITY_ERR  output  1  parity result of the last frame; valid with READY_RX and held afterwards.
- FRAME_ERR  output  1  stop bit sampled 0 in the last frame; valid with READY_RX and held afterwards.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (RESET=0, takes effect immediately):
  - State goes to IDLE and the counter to 0.
  - Both synchronizer flops go to 1.
  - DATA_RX_O=0x00; READY_RX, PARITY_ERR, FRAME_ERR and BUSY all 0.
  - A reset mid-frame abandons the frame and does not pulse READY_RX.
- Synchronizer: RX_I passes through 2 flops to give rx_s. All decisions use rx_s, which lags RX_I by 2 cycles.
- H = WORK_FR >> 1 (mid-bit sample point).
- States: IDLE, START, DATA, PARITY, STOP. Binary encoding; any illegal encoding returns to IDLE.
- IDLE:
  - On rx_s==0, go to START with counter=0 and bit index=0.
  - Otherwise stay; counter held at 0.
- Counter, in every non-IDLE state:
  - Increments by 1 each cycle.
  - When counter==WORK_FR, it clears to 0 and the state advances.
  - Each state except STOP therefore lasts exactly WORK_FR+1 cycles.
- START: at counter==H, sample rx_s. If 1 (glitch), return to IDLE next cycle, with no READY_RX and no flag changes.
- DATA:
  - At counter==H, shift rx_s into the MSB of an 8-bit shift register, so bit 0 ends up as the LSB.
  - Each time counter==WORK_FR, bit index increments.
  - After index 7 completes, go to PARITY.
- PARITY: at counter==H, latch p = rx_s.
- STOP: at counter==H, sample rx_s, then in the same edge:
  - DATA_RX_O <= shift register.
  - PARITY_ERR <= p XOR (XOR of the 8 data bits).
  - FRAME_ERR <= ~rx_s.
  - READY_RX <= 1 for exactly one cycle.
  - state <= IDLE (STOP is exited at mid-bit so the next start edge can be caught).
- Timing. Let T0 be the edge at which IDLE sees rx_s==0.
  - START sample at edge T0+1+H.
  - Data bit k sample at edge T0+1+(k+1)(WORK_FR+1)+H.
  - Parity sample at edge T0+1+9(WORK_FR+1)+H.
  - STOP sample at edge T0+1+10(WORK_FR+1)+H; READY_RX is high in the cycle following that edge.
- Back-to-back frames:
  - A start bit arriving immediately after the stop bit is detected.
  - IDLE is re-entered at least (WORK_FR+1)/2 cycles before the next falling edge.
- A line held low (break):
  - Produces a frame with DATA_RX_O=0x00, PARITY_ERR=0, FRAME_ERR=1.
  - IDLE then re-detects rx_s==0 and starts a new frame. Repeated framing errors are the required behaviour.
- No FIFO. A new frame overwrites DATA_RX_O and the flags whether or not the consumer has read them.

Test Plan:
- WORK_FR=15, drive frame for 0xA5 with parity 0 and stop 1, 16 cycles per bit -> one READY_RX pulse; DATA_RX_O=0xA5, PARITY_ERR=0, FRAME_ERR=0; pulse timing exactly as given by the formula above.
- Loopback from the transmitter, WORK_FR=15, bytes 0x00, 0xFF, 0x01, 0x80 sent back-to-back -> four READY_RX pulses, bytes in order, no error flags.
- 0x01 sent with parity bit 0 -> DATA_RX_O=0x01, PARITY_ERR=1, FRAME_ERR=0.
- 0x3C sent with stop bit 0 -> FRAME_ERR=1, DATA_RX_O=0x3C.
- 5-cycle low glitch on RX_I with WORK_FR=15 -> returns to IDLE from START; no READY_RX; outputs unchanged.
- RESET pulled low during DATA bit 4, then released, then a full 0x5A frame -> no pulse for the aborted frame; BUSY=0 during reset; 0x5A received with no flags.
